// File: rtl/image_pixel_streamer_pkg.sv
// Shared accelerator definitions: default pixel/frame geometry and the
// streamer FSM encoding.
package image_pixel_streamer_pkg;

    localparam int BITSIZE_DEFAULT = 18;
    localparam int IMG_W_DEFAULT   = 224;
    localparam int IMG_H_DEFAULT   = 224;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry in-order pixel buffer between the frame-buffer read port and the
// window FIFO. The head entry stays stable until it is popped.
module pixel_skid_buffer #(
    parameter int WIDTH = 56
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] tail;

    // NOTE: the entry registers are reset too, so pixel outputs read zero
    // straight out of reset instead of whatever the flops powered up with.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        tail  <= push_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Upstream credit accounting never pushes into a full
                    // buffer unless the head leaves in the same cycle.
                    if (pop) begin
                        head <= tail;
                        if (push) tail  <= push_data;
                        else      count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign valid = (count != 2'd0);

endmodule

// File: rtl/image_pixel_streamer.sv
// Reads a frame from the frame buffer in raster order and streams RGB pixels
// to the window FIFO with end-of-row / last-pixel qualifiers.
module image_pixel_streamer
    import image_pixel_streamer_pkg::*;
#(
    parameter int bitsize = BITSIZE_DEFAULT,
    parameter int IMG_W   = IMG_W_DEFAULT,
    parameter int IMG_H   = IMG_H_DEFAULT,
    parameter int ADDR_W  = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ready,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [bitsize-1:0] mem_dataR,
    input  logic [bitsize-1:0] mem_dataG,
    input  logic [bitsize-1:0] mem_dataB,
    output logic [bitsize-1:0] input_pixelR,
    output logic [bitsize-1:0] input_pixelG,
    output logic [bitsize-1:0] input_pixelB,
    output logic               wr_en,
    output logic               end_of_row,
    output logic               last_pixel,
    output logic               busy,
    output logic               done
);

    localparam int ENTRY_W = 3 * bitsize + 2;
    localparam int COL_W   = $clog2(IMG_W + 1);
    localparam int ROW_W   = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    stream_state_t state, state_nx;
    logic          done_nx;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;

    logic inflight, inflight_eor, inflight_last;

    logic               buf_valid;
    logic [1:0]         buf_count;
    logic [ENTRY_W-1:0] buf_head;

    logic       pop, issue, issue_last, frame_start, final_xfer;
    logic [2:0] slots_used;

    // Entries that will still be held or arriving after this cycle's pop;
    // a new read is allowed only while that stays below the buffer depth.
    assign pop         = buf_valid & ready;
    assign slots_used  = 3'(buf_count) + 3'(inflight) - 3'(pop);
    assign issue       = (state == STREAM) && (slots_used < 3'd2);
    assign issue_last  = (col == COL_LAST) && (row == ROW_LAST);
    assign frame_start = (state == IDLE) && start;
    assign final_xfer  = pop && buf_head[0];

    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE:   if (start) state_nx = STREAM;
            STREAM: if (issue && issue_last) state_nx = DRAIN;
            DRAIN: begin
                if (final_xfer) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            done          <= 1'b0;
            col           <= '0;
            row           <= '0;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_eor  <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nx;
            done          <= done_nx;
            inflight      <= issue;
            inflight_eor  <= issue && (col == COL_LAST);
            inflight_last <= issue && issue_last;
            if (frame_start) begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end else if (issue && !issue_last) begin
                addr <= addr + ADDR_W'(1);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Returning data is pushed only when a read is tracked as in flight, so
    // words for reads issued before a reset are dropped.
    pixel_skid_buffer #(
        .WIDTH(ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({mem_dataR, mem_dataG, mem_dataB, inflight_eor, inflight_last}),
        .pop       (pop),
        .valid     (buf_valid),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign mem_rd_en    = issue;
    assign mem_addr     = addr;
    assign wr_en        = buf_valid;
    assign input_pixelR = buf_head[ENTRY_W-1 -: bitsize];
    assign input_pixelG = buf_head[2*bitsize+1 -: bitsize];
    assign input_pixelB = buf_head[bitsize+1 -: bitsize];
    assign end_of_row   = buf_valid & buf_head[1];
    assign last_pixel   = buf_valid & buf_head[0];
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Self-checking bench for image_pixel_streamer on a 4x3 frame; memory word at
// address a is {R=a, G=a+100, B=a+200}.
module tb_image_pixel_streamer;

    localparam int BW     = 18;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int ADDR_W = 4;
    localparam int NPIX   = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst, start, ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [BW-1:0]     mem_dataR = '0, mem_dataG = '0, mem_dataB = '0;
    logic [BW-1:0]     input_pixelR, input_pixelG, input_pixelB;
    logic              wr_en, end_of_row, last_pixel, busy, done;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [BW-1:0] r, g, b;
        logic          eor, last;
    } pix_t;

    typedef struct {
        logic          start;
        logic          busy;
        logic          rd;
        logic [31:0]   addr;
        logic          wr;
        logic [BW-1:0] r;
        logic          eor;
        logic          last;
        logic          done;
    } vec_t;

    vec_t tbl[17];

    image_pixel_streamer #(
        .bitsize(BW), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ready        (ready),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_dataR    (mem_dataR),
        .mem_dataG    (mem_dataG),
        .mem_dataB    (mem_dataB),
        .input_pixelR (input_pixelR),
        .input_pixelG (input_pixelG),
        .input_pixelB (input_pixelB),
        .wr_en        (wr_en),
        .end_of_row   (end_of_row),
        .last_pixel   (last_pixel),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Frame buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_dataR <= BW'(mem_addr);
            mem_dataG <= BW'(mem_addr) + BW'(100);
            mem_dataB <= BW'(mem_addr) + BW'(200);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one frame against a queue-based model of the expected pixel stream.
    task automatic stream_frame(input int pct, input int restart_at, input int trail, input string tag);
        pix_t exp_q[$];
        pix_t e, held;
        bit   held_valid = 0;
        int   got = 0, dones = 0, next_rd = 0, post = 0, cyc = 0, last_cyc = -10;
        for (int a = 0; a < NPIX; a++) begin
            e.r = BW'(a); e.g = BW'(a + 100); e.b = BW'(a + 200);
            e.eor = ((a % IMG_W) == IMG_W - 1); e.last = (a == NPIX - 1);
            exp_q.push_back(e);
        end
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (post <= trail && cyc < 400) begin
            ready = ($urandom_range(99) < pct);
            start = (restart_at >= 0 && got == restart_at);
            #1;
            if (mem_rd_en) begin
                check({tag, " rd_addr"}, mem_addr, next_rd);
                next_rd++;
            end
            if (held_valid) begin
                check({tag, " hold_wr_en"}, wr_en, 1);
                check({tag, " hold_R"}, input_pixelR, held.r);
                check({tag, " hold_G"}, input_pixelG, held.g);
                check({tag, " hold_B"}, input_pixelB, held.b);
                check({tag, " hold_eor"}, end_of_row, held.eor);
                check({tag, " hold_last"}, last_pixel, held.last);
            end
            if (wr_en && ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, " pixel_count"}, got + 1, NPIX);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " R"}, input_pixelR, e.r);
                    check({tag, " G"}, input_pixelG, e.g);
                    check({tag, " B"}, input_pixelB, e.b);
                    check({tag, " eor"}, end_of_row, e.eor);
                    check({tag, " last"}, last_pixel, e.last);
                end
                got++;
                if (last_pixel) last_cyc = cyc;
            end
            held_valid = wr_en && !ready;
            held.r = input_pixelR; held.g = input_pixelG; held.b = input_pixelB;
            held.eor = end_of_row; held.last = last_pixel;
            if (done) begin
                dones++;
                check({tag, " done_timing"}, cyc, last_cyc + 1);
                check({tag, " busy_at_done"}, busy, 0);
            end
            @(negedge clk);
            cyc++;
            if (dones > 0) post++;
        end
        check({tag, " pixels_received"}, got, NPIX);
        check({tag, " reads_issued"}, next_rd, NPIX);
        check({tag, " done_pulses"}, dones, 1);
        if (trail > 0) check({tag, " idle_after"}, busy, 0);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rd_cnt, wait_cyc, exp_r;
        bit found, seen_done;

        rst = 1'b0; start = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset wr_en", wr_en, 0);
        check("reset mem_rd_en", mem_rd_en, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset R", input_pixelR, 0);
        check("reset G", input_pixelG, 0);
        check("reset B", input_pixelB, 0);
        check("reset eor", end_of_row, 0);
        check("reset last", last_pixel, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Cycle-exact timeline for a full-rate frame: reads in cycles 1..12,
        // pixels in cycles 3..14, done in cycle 15.
        for (int c = 0; c < 17; c++) begin
            tbl[c].start = (c == 0);
            tbl[c].busy  = (c >= 1 && c <= 14);
            tbl[c].rd    = (c >= 1 && c <= 12);
            tbl[c].addr  = 32'(c - 1);
            tbl[c].wr    = (c >= 3 && c <= 14);
            tbl[c].r     = BW'(c - 3);
            tbl[c].eor   = tbl[c].wr && (((c - 3) % IMG_W) == IMG_W - 1);
            tbl[c].last  = tbl[c].wr && (c - 3 == NPIX - 1);
            tbl[c].done  = (c == 15);
        end
        for (int c = 0; c < 17; c++) begin
            start = tbl[c].start; ready = 1'b1;
            #1;
            check($sformatf("tbl[%0d] busy", c), busy, tbl[c].busy);
            check($sformatf("tbl[%0d] done", c), done, tbl[c].done);
            check($sformatf("tbl[%0d] mem_rd_en", c), mem_rd_en, tbl[c].rd);
            check($sformatf("tbl[%0d] wr_en", c), wr_en, tbl[c].wr);
            if (tbl[c].rd) check($sformatf("tbl[%0d] mem_addr", c), mem_addr, tbl[c].addr);
            if (tbl[c].wr) begin
                check($sformatf("tbl[%0d] R", c), input_pixelR, tbl[c].r);
                check($sformatf("tbl[%0d] G", c), input_pixelG, tbl[c].r + BW'(100));
                check($sformatf("tbl[%0d] B", c), input_pixelB, tbl[c].r + BW'(200));
                check($sformatf("tbl[%0d] eor", c), end_of_row, tbl[c].eor);
                check($sformatf("tbl[%0d] last", c), last_pixel, tbl[c].last);
            end
            @(negedge clk);
        end
        start = 1'b0;

        // Back-pressure from the first pixel: two reads outstanding, then stall.
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        rd_cnt = 0; wait_cyc = 0;
        #1;
        while (!wr_en && wait_cyc < 10) begin
            if (mem_rd_en) rd_cnt++;
            @(negedge clk); #1;
            wait_cyc++;
        end
        check("stall first_wr_latency", wait_cyc, 2);
        for (int k = 0; k < 5; k++) begin
            if (mem_rd_en) rd_cnt++;
            check("stall wr_en", wr_en, 1);
            check("stall R_held", input_pixelR, 0);
            check("stall B_held", input_pixelB, 200);
            check("stall mem_rd_en", mem_rd_en, 0);
            @(negedge clk); #1;
        end
        check("stall reads_outstanding", rd_cnt, 2);
        ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("resume wr_en", wr_en, 1);
            check("resume R", input_pixelR, k);
            @(negedge clk); #1;
        end
        exp_r = 3; seen_done = 0;
        for (int i = 0; i < 30 && !seen_done; i++) begin
            if (wr_en) begin
                check("resume drain R", input_pixelR, exp_r);
                exp_r++;
            end
            if (done) seen_done = 1;
            @(negedge clk); #1;
        end
        check("resume drain count", exp_r, NPIX);
        check("resume done_seen", seen_done, 1);
        @(negedge clk);

        stream_frame(50, -1, 2, "random50");
        stream_frame(70, 5, 3, "restart_ignored");
        stream_frame(100, -1, 0, "b2b_first");
        stream_frame(100, -1, 2, "b2b_second");
        stream_frame(30, -1, 2, "random30");

        // Mid-frame reset while pixel 6 is presented.
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (wr_en && input_pixelR == 6) found = 1;
            else @(negedge clk);
        end
        check("midrst reached_pixel6", found, 1);
        rst = 1'b0;
        @(negedge clk); #1;
        check("midrst wr_en", wr_en, 0);
        check("midrst mem_rd_en", mem_rd_en, 0);
        check("midrst mem_addr", mem_addr, 0);
        check("midrst R", input_pixelR, 0);
        check("midrst G", input_pixelG, 0);
        check("midrst B", input_pixelB, 0);
        check("midrst eor", end_of_row, 0);
        check("midrst last", last_pixel, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        stream_frame(100, -1, 2, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
